// File: rtl/temp_sample_ctrl.sv
// Periodic ADC sampler: averages 2^AVG_LOG2 samples and reports degrees C and F.
// Optional build macro TEMP_ALARM_EN adds a hysteretic over-temperature alarm output.
module temp_sample_ctrl #(
  parameter int SAMPLE_PERIOD = 1000,
  parameter int AVG_LOG2      = 2,
  parameter int TIMEOUT       = 256,
  parameter int ALARM_HI      = 60,
  parameter int ALARM_LO      = 55
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  output logic        adc_req,
  input  logic        adc_valid,
  input  logic [15:0] adc_data,
  output logic [15:0] c,
  output logic [15:0] f,
  output logic        data_valid,
  output logic        err
`ifdef TEMP_ALARM_EN
  ,
  output logic        alarm
`endif
);

  localparam int AW = 16 + AVG_LOG2;
  localparam logic [AVG_LOG2:0] LAST_N = (AVG_LOG2 + 1)'((1 << AVG_LOG2) - 1);

  if (SAMPLE_PERIOD < 1 || SAMPLE_PERIOD > (1 << 20)) begin : g_bad_period
    $error("temp_sample_ctrl: SAMPLE_PERIOD out of range");
  end
  if (AVG_LOG2 < 0 || AVG_LOG2 > 4 || TIMEOUT < 1) begin : g_bad_avg
    $error("temp_sample_ctrl: AVG_LOG2 or TIMEOUT out of range");
  end
  if (ALARM_LO > ALARM_HI) begin : g_bad_alarm
    $error("temp_sample_ctrl: ALARM_LO above ALARM_HI");
  end

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_REQ, S_CONV} state_t;

  state_t            state, state_nx;
  logic [31:0]       cnt;
  logic [AW-1:0]     acc, sum;
  logic [AVG_LOG2:0] n;
  logic              en_q, abort;
  logic              hs, tmo, keep, last;
  logic [15:0]       avg, c_new, f_new;

  assign hs   = (state == S_REQ) && adc_valid;
  assign tmo  = (state == S_REQ) && !adc_valid && (cnt == 32'(TIMEOUT - 1));
  assign keep = enable && !abort;
  assign last = (n == LAST_N);
  assign adc_req = (state == S_REQ);

  assign avg   = 16'(sum >> AVG_LOG2);
  assign c_new = 16'((32'(avg) * 32'd300) >> 10);
  assign f_new = 16'((32'(c_new) * 32'd9) / 32'd5 + 32'd32);

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (enable) state_nx = S_WAIT;
      S_WAIT: begin
        if (!enable)                                 state_nx = S_IDLE;
        else if (cnt == 32'(SAMPLE_PERIOD - 1))      state_nx = S_REQ;
      end
      S_REQ: begin
        if (hs)       state_nx = !keep ? S_IDLE : (last ? S_CONV : S_WAIT);
        else if (tmo) state_nx = keep ? S_WAIT : S_IDLE;
      end
      S_CONV: state_nx = enable ? S_WAIT : S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
      abort <= 1'b0;
      en_q  <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_nx;
      en_q  <= enable;
      // one counter serves both the WAIT period and the REQ timeout
      if (state_nx != state)
        cnt <= '0;
      else if (state == S_WAIT || state == S_REQ)
        cnt <= cnt + 32'd1;
      // a request that outlives a drop of enable must end in IDLE even if enable returns
      if (state == S_REQ && state_nx == S_REQ)
        abort <= abort | ~enable;
      else
        abort <= 1'b0;
      if (tmo)
        err <= 1'b1;
      else if (enable && !en_q)
        err <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      n   <= '0;
      sum <= '0;
    end else begin
      if (hs && state_nx == S_CONV)
        sum <= acc + AW'(adc_data);
      if (state_nx == S_IDLE || state_nx == S_CONV || tmo) begin
        acc <= '0;
        n   <= '0;
      end else if (hs) begin
        acc <= acc + AW'(adc_data);
        n   <= n + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c          <= '0;
      f          <= '0;
      data_valid <= 1'b0;
    end else begin
      data_valid <= (state == S_CONV);
      if (state == S_CONV) begin
        c <= c_new;
        f <= f_new;
      end
    end
  end

`ifdef TEMP_ALARM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      alarm <= 1'b0;
    else if (state == S_CONV) begin
      if (c_new >= 16'(ALARM_HI))
        alarm <= 1'b1;
      else if (c_new < 16'(ALARM_LO))
        alarm <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_temp_sample_ctrl.sv
// Directed bench for temp_sample_ctrl: averaging vectors, timeout, enable drop, reset mid-request.
module tb_temp_sample_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, enable, adc_valid;
  logic [15:0] adc_data;
  logic        adc_req, data_valid, err;
  logic [15:0] c, f;
`ifdef TEMP_ALARM_EN
  logic        alarm;
`endif

  int total = 0;
  int bad   = 0;

  temp_sample_ctrl #(
    .SAMPLE_PERIOD(4), .AVG_LOG2(2), .TIMEOUT(8), .ALARM_HI(60), .ALARM_LO(55)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .adc_req(adc_req),
    .adc_valid(adc_valid), .adc_data(adc_data), .c(c), .f(f),
    .data_valid(data_valid), .err(err)
`ifdef TEMP_ALARM_EN
    , .alarm(alarm)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0][15:0] s;
    logic [15:0]      ec;
    logic [15:0]      ef;
    logic             ea;
  } vec_t;

  vec_t alarm_tbl[4];
  vec_t main_tbl[5];

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic feed_one(input logic [15:0] d);
    int k;
    k = 0;
    while (!adc_req && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (!adc_req) check("req_wait_timeout", 0, 1);
    adc_valid = 1'b1;
    adc_data  = d;
    @(posedge clk);
    #1 adc_valid = 1'b0;
  endtask

  task automatic run_batch(input string nm, input vec_t v, input logic chk_a);
    for (int i = 0; i < 4; i++) feed_one(v.s[i]);
    @(negedge clk);
    check({nm, "_dv_early"}, 32'(data_valid), 0);
    @(negedge clk);
    check({nm, "_dv"}, 32'(data_valid), 1);
    check({nm, "_c"}, 32'(c), 32'(v.ec));
    check({nm, "_f"}, 32'(f), 32'(v.ef));
`ifdef TEMP_ALARM_EN
    if (chk_a) check({nm, "_alarm"}, 32'(alarm), 32'(v.ea));
`else
    if (chk_a) check({nm, "_no_err"}, 32'(err), 0);
`endif
    @(negedge clk);
    check({nm, "_dv_pulse"}, 32'(data_valid), 0);
  endtask

  initial begin
    int cnt_hi;
    logic seen_dv;
    logic [15:0] c_keep, f_keep;

    alarm_tbl[0] = '{s: {4{16'd198}}, ec: 16'd58, ef: 16'd136, ea: 1'b0};
    alarm_tbl[1] = '{s: {4{16'd209}}, ec: 16'd61, ef: 16'd141, ea: 1'b1};
    alarm_tbl[2] = '{s: {4{16'd195}}, ec: 16'd57, ef: 16'd134, ea: 1'b1};
    alarm_tbl[3] = '{s: {4{16'd185}}, ec: 16'd54, ef: 16'd129, ea: 1'b0};
    main_tbl[0]  = '{s: {4{16'd1024}}, ec: 16'd300, ef: 16'd572, ea: 1'b0};
    main_tbl[1]  = '{s: {16'd100, 16'd200, 16'd300, 16'd400}, ec: 16'd73, ef: 16'd163, ea: 1'b0};
    main_tbl[2]  = '{s: {4{16'd0}}, ec: 16'd0, ef: 16'd32, ea: 1'b0};
    main_tbl[3]  = '{s: {4{16'd65535}}, ec: 16'd19199, ef: 16'd34590, ea: 1'b0};
    main_tbl[4]  = '{s: {4{16'd4000}}, ec: 16'd1171, ef: 16'd2139, ea: 1'b0};

    rst_n = 1'b0; enable = 1'b0; adc_valid = 1'b0; adc_data = '0;
    repeat (3) @(negedge clk);
    check("rst_req", 32'(adc_req), 0);
    check("rst_c", 32'(c), 0);
    check("rst_f", 32'(f), 0);
    check("rst_dv", 32'(data_valid), 0);
    check("rst_err", 32'(err), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_no_req", 32'(adc_req), 0);
    enable = 1'b1;

    for (int i = 0; i < 4; i++) run_batch($sformatf("alarm%0d", i), alarm_tbl[i], 1'b1);
    for (int i = 0; i < 5; i++) run_batch($sformatf("vec%0d", i), main_tbl[i], 1'b0);

    // timeout: withhold adc_valid and count request cycles
    cnt_hi = 0; seen_dv = 1'b0;
    for (int k = 0; k < 100 && cnt_hi == 0; k++) begin
      @(negedge clk);
      if (adc_req) cnt_hi = 1;
    end
    for (int k = 0; k < 50 && adc_req; k++) begin
      @(negedge clk);
      if (data_valid) seen_dv = 1'b1;
      if (adc_req) cnt_hi++;
    end
    check("tmo_req_cycles", 32'(cnt_hi), 8);
    check("tmo_req_low", 32'(adc_req), 0);
    check("tmo_err", 32'(err), 1);
    check("tmo_no_dv", 32'(seen_dv), 0);
    enable = 1'b0;
    repeat (2) @(negedge clk);
    check("tmo_err_sticky", 32'(err), 1);
    enable = 1'b1;
    @(negedge clk);
    check("err_cleared", 32'(err), 0);

    // partial average abandoned by an enable drop must not leak into the next one
    feed_one(16'd65535);
    feed_one(16'd65535);
    @(negedge clk);
    enable = 1'b0;
    repeat (3) @(negedge clk);
    enable = 1'b1;
    run_batch("fresh", main_tbl[0], 1'b0);

    // enable drop while requesting; late sample is discarded
    c_keep = c; f_keep = f;
    for (int k = 0; k < 100 && !adc_req; k++) @(negedge clk);
    enable = 1'b0;
    repeat (2) @(negedge clk);
    check("drop_req_held", 32'(adc_req), 1);
    adc_valid = 1'b1; adc_data = 16'd9999;
    @(posedge clk);
    #1 adc_valid = 1'b0;
    @(negedge clk);
    check("drop_req_low", 32'(adc_req), 0);
    seen_dv = 1'b0; cnt_hi = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (data_valid) seen_dv = 1'b1;
      if (adc_req) cnt_hi++;
    end
    check("drop_no_dv", 32'(seen_dv), 0);
    check("drop_idle_no_req", 32'(cnt_hi), 0);
    check("drop_c_kept", 32'(c), 32'(c_keep));
    check("drop_f_kept", 32'(f), 32'(f_keep));

    // reset in the middle of a request
    enable = 1'b1;
    for (int k = 0; k < 100 && !adc_req; k++) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_req", 32'(adc_req), 0);
    check("mid_rst_c", 32'(c), 0);
    check("mid_rst_f", 32'(f), 0);
    check("mid_rst_dv", 32'(data_valid), 0);
    enable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    adc_valid = 1'b1; adc_data = 16'd5000;
    @(posedge clk);
    #1 adc_valid = 1'b0;
    seen_dv = 1'b0; cnt_hi = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (data_valid) seen_dv = 1'b1;
      if (adc_req) cnt_hi++;
    end
    check("late_valid_no_dv", 32'(seen_dv), 0);
    check("late_valid_no_req", 32'(cnt_hi), 0);
    check("late_valid_c", 32'(c), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
